reg_dump_monitor: RTL and testbench

REG_DUMP_MONITOR -- requirements
Module: reg_dump_monitor

---
 rtl/reg_dump_monitor.sv | 81 ++++++++
 tb/tb_reg_dump_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_monitor.sv
// reg_dump_monitor: counts CPU run cycles, stalls on halt or cycle limit, then streams the register file out
module reg_dump_monitor #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 16,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CNT_W-1:0]  end_count_i,
  input  logic              halt_en_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              cpu_stall_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              stop_reason_o,
  output logic              done_o
);
  localparam logic [1:0] RUN = 2'd0, READ = 2'd1, SEND = 2'd2, DONE = 2'd3;
  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              last;
  logic              skip;
  // next count, last-register and zero-skip decode; status outputs follow the state directly
  always_comb begin
    cnt_nx       = cycle_cnt_o + CNT_W'(1);
    last         = idx == ADDR_W'(NUM_REGS - 1);
    skip         = (SKIP_ZERO != 0) && (rf_rdata_i == '0);
    rf_raddr_o   = idx;
    cpu_stall_o  = state != RUN;
    dump_valid_o = state == SEND;
    done_o       = state == DONE;
  end
  // run counting, stop detection, and the read/send walk over the register indices
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= RUN;
      cycle_cnt_o   <= '0;
      idx           <= '0;
      dump_idx_o    <= '0;
      dump_data_o   <= '0;
      stop_reason_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cycle_cnt_o <= &cycle_cnt_o ? cycle_cnt_o : cnt_nx;
          if (halt_en_i && halt_i) begin
            state         <= READ;
            stop_reason_o <= 1'b1;
            idx           <= '0;
          end else if (end_count_i != '0 && cnt_nx == end_count_i) begin
            state         <= READ;
            stop_reason_o <= 1'b0;
            idx           <= '0;
          end
        end
        READ: begin
          dump_data_o <= rf_rdata_i;
          dump_idx_o  <= idx;
          if (!skip) state <= SEND;
          else if (last) state <= DONE;
          else idx <= idx + ADDR_W'(1);
        end
        SEND: begin
          if (dump_ready_i) begin
            state <= last ? DONE : READ;
            if (!last) idx <= idx + ADDR_W'(1);
          end
        end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_dump_monitor.sv
// tb_reg_dump_monitor: table-driven stop vectors plus directed dump, reset and skip sequences
module tb_reg_dump_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst;
  logic [15:0] end_count;
  logic        halt_en, halt, ready, stall, valid, reason, done;
  logic [4:0]  raddr, didx;
  logic [31:0] rdata, ddata;
  logic [15:0] cnt;
  logic [31:0] rf [32];
  assign rdata = rf[raddr];
  logic [3:0]  end2, cnt2;
  logic        halt_en2, halt2, ready2, stall2, valid2, reason2, done2;
  logic [4:0]  raddr2, didx2;
  logic [31:0] rdata2, ddata2;
  logic [31:0] rf2 [32];
  assign rdata2 = rf2[raddr2];

  reg_dump_monitor dut (
    .clk_i(clk), .rst_i(rst), .end_count_i(end_count), .halt_en_i(halt_en), .halt_i(halt),
    .rf_raddr_o(raddr), .rf_rdata_i(rdata), .cpu_stall_o(stall), .dump_valid_o(valid),
    .dump_ready_i(ready), .dump_idx_o(didx), .dump_data_o(ddata), .cycle_cnt_o(cnt),
    .stop_reason_o(reason), .done_o(done)
  );

  reg_dump_monitor #(.CNT_W(4), .SKIP_ZERO(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .end_count_i(end2), .halt_en_i(halt_en2), .halt_i(halt2),
    .rf_raddr_o(raddr2), .rf_rdata_i(rdata2), .cpu_stall_o(stall2), .dump_valid_o(valid2),
    .dump_ready_i(ready2), .dump_idx_o(didx2), .dump_data_o(ddata2), .cycle_cnt_o(cnt2),
    .stop_reason_o(reason2), .done_o(done2)
  );

  typedef struct {
    logic [15:0] end_cnt;
    logic        he;
    int          halt_at;
    logic [15:0] exp_cnt;
    logic        exp_reason;
  } vec_t;
  vec_t vt [6];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_reason"}, reason, 0);
    chk({tag, "_didx"}, didx, 0);
    chk({tag, "_ddata"}, ddata, 0);
    chk({tag, "_raddr"}, raddr, 0);
  endtask

  task automatic wait_stop(input int h, output int cyc);
    cyc = -1;
    for (int c = 0; c < 300; c++) begin
      if (stall) begin
        cyc = c;
        halt = 1'b0;
        return;
      end
      halt = (h != 0) && (cnt == 16'(h - 1));
      @(negedge clk);
    end
    halt = 1'b0;
    chk("stop_timeout", 0, 1);
  endtask

  task automatic drain(input bit rnd, output int lat);
    int n = 0;
    int d = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [4:0] pi = '0;
    logic [31:0] pd = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (pv && !pr) begin
        chk("hold_valid", valid, 1);
        chk("hold_idx", didx, pi);
        chk("hold_data", ddata, pd);
      end
      if (rnd) begin
        ready = 1'($urandom_range(0, 1));
        halt = 1'($urandom_range(0, 1));
        end_count = 16'($urandom);
      end
      if (valid && ready) begin
        chk("entry_idx", didx, n);
        chk("entry_data", ddata, n * 3);
        n++;
      end
      pv = valid;
      pr = ready;
      pi = didx;
      pd = ddata;
      @(negedge clk);
      d++;
    end
    chk("entries", n, 32);
    chk("done", done, 1);
    chk("done_valid", valid, 0);
    chk("done_stall", stall, 1);
    lat = d;
  endtask

  initial begin
    int cyc, lat, n;
    bit found;
    logic [4:0]  ei [2];
    logic [31:0] ed [2];
    ei[0] = 5'd5;  ed[0] = 32'd7;
    ei[1] = 5'd31; ed[1] = 32'd9;
    vt[0] = '{16'd100, 1'b0, 0,  16'd100, 1'b0};
    vt[1] = '{16'd10,  1'b1, 10, 16'd10,  1'b1};
    vt[2] = '{16'd0,   1'b1, 5,  16'd5,   1'b1};
    vt[3] = '{16'd1,   1'b0, 0,  16'd1,   1'b0};
    vt[4] = '{16'd50,  1'b0, 3,  16'd50,  1'b0};
    vt[5] = '{16'd20,  1'b1, 25, 16'd20,  1'b0};
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'(i * 3);
      rf2[i] = '0;
    end
    rf2[5] = 32'd7;
    rf2[31] = 32'd9;
    rst = 1'b1; end_count = '0; halt_en = 1'b0; halt = 1'b0; ready = 1'b1;
    end2 = '0; halt_en2 = 1'b0; halt2 = 1'b0; ready2 = 1'b1;

    for (int i = 0; i < 6; i++) begin
      end_count = vt[i].end_cnt;
      halt_en = vt[i].he;
      ready = 1'b1;
      do_reset();
      if (i == 0) check_reset("rst");
      wait_stop(vt[i].halt_at, cyc);
      chk("stop_cyc", cyc, vt[i].exp_cnt);
      chk("stop_cnt", cnt, vt[i].exp_cnt);
      chk("stop_reason", reason, vt[i].exp_reason);
      chk("read_valid", valid, 0);
      drain(1'b0, lat);
      chk("done_lat", lat, 64);
      chk("frozen_cnt", cnt, vt[i].exp_cnt);
    end

    end_count = 16'd100; halt_en = 1'b1; ready = 1'b1;
    do_reset();
    halt_en = 1'b0;
    wait_stop(0, cyc);
    chk("rnd_stop_cnt", cnt, 100);
    drain(1'b1, lat);
    chk("rnd_reason", reason, 0);
    chk("rnd_cnt", cnt, 100);

    end_count = 16'd30; halt_en = 1'b0; halt = 1'b0; ready = 1'b1;
    do_reset();
    wait_stop(0, cyc);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (valid && didx == 5'd12) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("send12_found", found, 1);
    chk("send12_data", ddata, 36);
    end_count = '0;
    do_reset();
    check_reset("midrst");
    repeat (3) @(negedge clk);
    chk("restart_cnt", cnt, 3);
    chk("restart_stall", stall, 0);

    do_reset();
    repeat (40) @(negedge clk);
    chk("sat_cnt", cnt2, 15);
    chk("sat_stall", stall2, 0);
    chk("sat_done", done2, 0);
    halt_en2 = 1'b1;
    halt2 = 1'b1;
    @(negedge clk);
    halt2 = 1'b0;
    chk("skip_stall", stall2, 1);
    chk("skip_reason", reason2, 1);
    chk("skip_cnt", cnt2, 15);
    n = 0;
    for (int c = 0; c < 200 && !done2; c++) begin
      if (valid2 && ready2) begin
        if (n < 2) begin
          chk("skip_idx", didx2, ei[n]);
          chk("skip_data", ddata2, ed[n]);
        end
        n++;
      end
      @(negedge clk);
    end
    chk("skip_entries", n, 2);
    chk("skip_done", done2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
